// File: rtl/map_table_nway.sv
// rtl/map_table_nway.sv - N-wide register alias table with intra-group forwarding and CDB bypass
module map_table_nway #(
    parameter int WIDTH     = 3,
    parameter int ARCH_REGS = 32,
    parameter int ROB_SIZE  = 32,
    parameter int ZERO_REG  = 1,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int TW = $clog2(ROB_SIZE),
    localparam int NW = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dispatch_en,
    input  logic [NW-1:0]         dispatch_num,
    input  logic [WIDTH*AW-1:0]   src1_idx,
    input  logic [WIDTH*AW-1:0]   src2_idx,
    input  logic [WIDTH*AW-1:0]   dest_idx,
    input  logic [TW-1:0]         rob_tail_in,
    input  logic                  complete_en,
    input  logic [NW-1:0]         complete_num,
    input  logic [WIDTH*TW-1:0]   cdb_tag_in,
    input  logic                  retire_en,
    input  logic [NW-1:0]         retire_num,
    input  logic [WIDTH*AW-1:0]   retire_dest_idx,
    input  logic [WIDTH*TW-1:0]   retire_tag,
    input  logic                  flush,
    output logic [WIDTH*TW-1:0]   tag_out1,
    output logic [WIDTH*TW-1:0]   tag_out2,
    output logic [WIDTH-1:0]      ready_out1,
    output logic [WIDTH-1:0]      ready_out2,
    output logic [WIDTH-1:0]      hit1,
    output logic [WIDTH-1:0]      hit2,
    output logic [ARCH_REGS-1:0]  ready_vec
);

    logic [ARCH_REGS-1:0] valid_q, ready_q, valid_d, ready_d;
    logic [TW-1:0]        tag_q [ARCH_REGS];
    logic [TW-1:0]        tag_d [ARCH_REGS];

    logic [NW-1:0]  disp_n, comp_n, ret_n;
    logic [WIDTH-1:0] disp_write, comp_lane, ret_lane;
    logic [AW-1:0]  src1 [WIDTH];
    logic [AW-1:0]  src2 [WIDTH];
    logic [AW-1:0]  dest [WIDTH];
    logic [AW-1:0]  rdest [WIDTH];
    logic [TW-1:0]  lane_tag [WIDTH];
    logic [TW-1:0]  cdb_tag [WIDTH];
    logic [TW-1:0]  rtag [WIDTH];
    logic [ARCH_REGS-1:0] cdb_hit_reg;

    function automatic logic [NW-1:0] clamp(input logic [NW-1:0] n);
        return (n > NW'(WIDTH)) ? NW'(WIDTH) : n;
    endfunction

    assign disp_n = clamp(dispatch_num);
    assign comp_n = clamp(complete_num);
    assign ret_n  = clamp(retire_num);

    // Lane unpacking; disp_write already excludes writes to the hardwired zero register.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            src1[i]     = src1_idx[i*AW +: AW];
            src2[i]     = src2_idx[i*AW +: AW];
            dest[i]     = dest_idx[i*AW +: AW];
            rdest[i]    = retire_dest_idx[i*AW +: AW];
            cdb_tag[i]  = cdb_tag_in[i*TW +: TW];
            rtag[i]     = retire_tag[i*TW +: TW];
            lane_tag[i] = rob_tail_in + TW'(i);
            disp_write[i] = dispatch_en && (NW'(i) < disp_n) &&
                            !((ZERO_REG != 0) && (dest[i] == '0));
            comp_lane[i]  = complete_en && (NW'(i) < comp_n);
            ret_lane[i]   = retire_en && (NW'(i) < ret_n);
        end
    end

    always_comb begin
        cdb_hit_reg = '0;
        for (int r = 0; r < ARCH_REGS; r++) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (comp_lane[k] && (cdb_tag[k] == tag_q[r])) cdb_hit_reg[r] = 1'b1;
            end
        end
    end

    // Returns {hit, ready, tag}; younger in-group producers override the table.
    function automatic logic [TW+1:0] lookup(input int j, input logic [AW-1:0] src);
        logic [TW+1:0] res;
        res = '0;
        if (!((ZERO_REG != 0) && (src == '0))) begin
            if (valid_q[src]) res = {1'b1, ready_q[src] | cdb_hit_reg[src], tag_q[src]};
            for (int i = 0; i < WIDTH; i++) begin
                if ((i < j) && disp_write[i] && (dest[i] == src)) res = {2'b10, lane_tag[i]};
            end
        end
        return res;
    endfunction

    always_comb begin
        logic [TW+1:0] r1, r2;
        tag_out1   = '0;
        tag_out2   = '0;
        ready_out1 = '0;
        ready_out2 = '0;
        hit1       = '0;
        hit2       = '0;
        for (int j = 0; j < WIDTH; j++) begin
            r1 = lookup(j, src1[j]);
            r2 = lookup(j, src2[j]);
            hit1[j]              = r1[TW+1];
            ready_out1[j]        = r1[TW];
            tag_out1[j*TW +: TW] = r1[TW-1:0];
            hit2[j]              = r2[TW+1];
            ready_out2[j]        = r2[TW];
            tag_out2[j*TW +: TW] = r2[TW-1:0];
        end
    end

    // Later loops override earlier ones: dispatch beats retire beats complete.
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        tag_d   = tag_q;
        for (int r = 0; r < ARCH_REGS; r++) begin
            if (valid_q[r] && cdb_hit_reg[r]) ready_d[r] = 1'b1;
        end
        for (int k = 0; k < WIDTH; k++) begin
            if (ret_lane[k] && valid_q[rdest[k]] && (tag_q[rdest[k]] == rtag[k]))
                valid_d[rdest[k]] = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (disp_write[i]) begin
                valid_d[dest[i]] = 1'b1;
                tag_d[dest[i]]   = lane_tag[i];
                ready_d[dest[i]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            ready_q <= '0;
            for (int r = 0; r < ARCH_REGS; r++) tag_q[r] <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            for (int r = 0; r < ARCH_REGS; r++) tag_q[r] <= tag_d[r];
        end
    end

    assign ready_vec = valid_q & ready_q;

endmodule

// File: tb/tb_map_table_nway.sv
// tb/tb_map_table_nway.sv - directed and randomized check of map_table_nway against a reference model
module tb_map_table_nway;
    localparam int WIDTH = 3;
    localparam int AW = 5;
    localparam int TW = 5;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic reset;
    logic dispatch_en, complete_en, retire_en, flush;
    logic [NW-1:0] dispatch_num, complete_num, retire_num;
    logic [WIDTH*AW-1:0] src1_idx, src2_idx, dest_idx, retire_dest_idx;
    logic [TW-1:0] rob_tail_in;
    logic [WIDTH*TW-1:0] cdb_tag_in, retire_tag, tag_out1, tag_out2;
    logic [WIDTH-1:0] ready_out1, ready_out2, hit1, hit2;
    logic [31:0] ready_vec;

    always #5 clk = ~clk;

    map_table_nway dut (
        .clk(clk), .reset(reset),
        .dispatch_en(dispatch_en), .dispatch_num(dispatch_num),
        .src1_idx(src1_idx), .src2_idx(src2_idx), .dest_idx(dest_idx),
        .rob_tail_in(rob_tail_in),
        .complete_en(complete_en), .complete_num(complete_num), .cdb_tag_in(cdb_tag_in),
        .retire_en(retire_en), .retire_num(retire_num),
        .retire_dest_idx(retire_dest_idx), .retire_tag(retire_tag),
        .flush(flush),
        .tag_out1(tag_out1), .tag_out2(tag_out2),
        .ready_out1(ready_out1), .ready_out2(ready_out2),
        .hit1(hit1), .hit2(hit2), .ready_vec(ready_vec)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]   mvalid, mready;
    logic [TW-1:0] mtag [32];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic bit on_cdb(input logic [TW-1:0] t);
        for (int k = 0; k < int'(complete_num); k++)
            if (complete_en && cdb_tag_in[k*TW +: TW] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Spec rules: nearest earlier lane writing src wins, else table entry, else miss.
    task automatic ref_lookup(input int j, input logic [AW-1:0] src,
                              output bit h, output logic [TW-1:0] t, output bit rd);
        h = 0; t = '0; rd = 0;
        if (src == 0) return;
        for (int i = j - 1; i >= 0; i--) begin
            if (dispatch_en && i < int'(dispatch_num) && dest_idx[i*AW +: AW] == src) begin
                h = 1; t = TW'((int'(rob_tail_in) + i) % 32); rd = 0;
                return;
            end
        end
        if (mvalid[src]) begin
            h = 1; t = mtag[src]; rd = mready[src] | on_cdb(mtag[src]);
        end
    endtask

    task automatic model_check();
        bit h, rd;
        logic [TW-1:0] t;
        for (int j = 0; j < WIDTH; j++) begin
            ref_lookup(j, src1_idx[j*AW +: AW], h, t, rd);
            check($sformatf("hit1[%0d]", j), 64'(hit1[j]), 64'(h));
            check($sformatf("tag1[%0d]", j), 64'(tag_out1[j*TW +: TW]), 64'(t));
            check($sformatf("rdy1[%0d]", j), 64'(ready_out1[j]), 64'(rd));
            ref_lookup(j, src2_idx[j*AW +: AW], h, t, rd);
            check($sformatf("hit2[%0d]", j), 64'(hit2[j]), 64'(h));
            check($sformatf("tag2[%0d]", j), 64'(tag_out2[j*TW +: TW]), 64'(t));
            check($sformatf("rdy2[%0d]", j), 64'(ready_out2[j]), 64'(rd));
        end
        check("ready_vec", 64'(ready_vec), 64'(mvalid & mready));
    endtask

    task automatic model_update();
        logic [31:0]   nv, nr;
        logic [TW-1:0] nt [32];
        logic [AW-1:0] d;
        if (reset || flush) begin
            mvalid = '0; mready = '0;
            return;
        end
        nv = mvalid; nr = mready; nt = mtag;
        for (int r = 0; r < 32; r++)
            if (mvalid[r] && on_cdb(mtag[r])) nr[r] = 1'b1;
        for (int k = 0; k < int'(retire_num); k++) begin
            d = retire_dest_idx[k*AW +: AW];
            if (retire_en && mvalid[d] && mtag[d] == retire_tag[k*TW +: TW]) nv[d] = 1'b0;
        end
        for (int i = 0; i < int'(dispatch_num); i++) begin
            d = dest_idx[i*AW +: AW];
            if (dispatch_en && d != 0) begin
                nv[d] = 1'b1; nr[d] = 1'b0; nt[d] = TW'((int'(rob_tail_in) + i) % 32);
            end
        end
        mvalid = nv; mready = nr; mtag = nt;
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        dispatch_en = 0; dispatch_num = '0; complete_en = 0; complete_num = '0;
        retire_en = 0; retire_num = '0; flush = 0;
        src1_idx = '0; src2_idx = '0; dest_idx = '0; retire_dest_idx = '0;
        rob_tail_in = '0; cdb_tag_in = '0; retire_tag = '0;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk); @(posedge clk);
        mvalid = '0; mready = '0;
        for (int r = 0; r < 32; r++) mtag[r] = '0;
        @(negedge clk);
        reset = 0;

        // 1: reset state
        src1_idx[0 +: AW] = 5'd1; src2_idx[0 +: AW] = 5'd2;
        #1;
        check("rst_hit1", 64'(hit1), 64'(0));
        check("rst_hit2", 64'(hit2), 64'(0));
        check("rst_rvec", 64'(ready_vec), 64'(0));
        step();

        // 2/3: dispatch r1,r2,r3 at tail 5 with intra-group sources
        dispatch_en = 1; dispatch_num = 2'd3; rob_tail_in = 5'd5;
        dest_idx = {5'd3, 5'd2, 5'd1};
        src1_idx = {5'd0, 5'd1, 5'd1};
        src2_idx = {5'd2, 5'd0, 5'd0};
        #1;
        check("fwd_nohit_l0", 64'(hit1[0]), 64'(0));
        check("fwd_hit_l1", 64'(hit1[1]), 64'(1));
        check("fwd_tag_l1", 64'(tag_out1[5 +: 5]), 64'(5));
        check("fwd_rdy_l1", 64'(ready_out1[1]), 64'(0));
        check("fwd_tag_l2", 64'(tag_out2[10 +: 5]), 64'(6));
        step();
        idle();
        src1_idx = {5'd0, 5'd3, 5'd1}; src2_idx[0 +: AW] = 5'd2;
        #1;
        check("tbl_tag_r1", 64'(tag_out1[0 +: 5]), 64'(5));
        check("tbl_tag_r2", 64'(tag_out2[0 +: 5]), 64'(6));
        check("tbl_tag_r3", 64'(tag_out1[5 +: 5]), 64'(7));
        check("tbl_rdy_r2", 64'(ready_out2[0]), 64'(0));
        step();

        // 4: CDB bypass then registered ready
        idle();
        complete_en = 1; complete_num = 2'd1; cdb_tag_in[0 +: TW] = 5'd6;
        src1_idx[0 +: AW] = 5'd1; src2_idx[0 +: AW] = 5'd2;
        #1;
        check("byp_rdy_r2", 64'(ready_out2[0]), 64'(1));
        check("byp_rdy_r1", 64'(ready_out1[0]), 64'(0));
        step();
        idle();
        #1;
        check("rvec2", 64'(ready_vec[2]), 64'(1));
        check("rvec1", 64'(ready_vec[1]), 64'(0));

        // 5: tag wrap, stale and matching retire
        dispatch_en = 1; dispatch_num = 2'd3; rob_tail_in = 5'd30;
        dest_idx = {5'd4, 5'd1, 5'd1};
        step();
        idle();
        src1_idx[0 +: AW] = 5'd1; src2_idx[0 +: AW] = 5'd4;
        #1;
        check("wrap_tag_r1", 64'(tag_out1[0 +: 5]), 64'(31));
        check("wrap_tag_r4", 64'(tag_out2[0 +: 5]), 64'(0));
        check("wrap_hit_r4", 64'(hit2[0]), 64'(1));
        retire_en = 1; retire_num = 2'd1; retire_dest_idx[0 +: AW] = 5'd1; retire_tag[0 +: TW] = 5'd5;
        step();
        retire_en = 0;
        #1;
        check("stale_keep", 64'(hit1[0]), 64'(1));
        retire_en = 1; retire_tag[0 +: TW] = 5'd31;
        step();
        retire_en = 0;
        #1;
        check("retire_clr", 64'(hit1[0]), 64'(0));

        // 6: zero register and flush
        idle();
        dispatch_en = 1; dispatch_num = 2'd1; rob_tail_in = 5'd9;
        step();
        idle();
        #1;
        check("zero_reg", 64'(hit1[0]), 64'(0));
        flush = 1; dispatch_en = 1; dispatch_num = 2'd1; dest_idx[0 +: AW] = 5'd5;
        step();
        idle();
        src1_idx[0 +: AW] = 5'd5; src2_idx[0 +: AW] = 5'd2;
        #1;
        check("flush_hit1", 64'(hit1[0]), 64'(0));
        check("flush_hit2", 64'(hit2[0]), 64'(0));
        check("flush_rvec", 64'(ready_vec), 64'(0));
        step();

        // Randomized traffic over a small register window to force collisions
        repeat (600) begin
            dispatch_en  = ($urandom_range(0, 3) != 0);
            dispatch_num = NW'($urandom_range(0, 3));
            rob_tail_in  = TW'($urandom);
            complete_en  = ($urandom_range(0, 2) != 0);
            complete_num = NW'($urandom_range(0, 3));
            retire_en    = ($urandom_range(0, 2) != 0);
            retire_num   = NW'($urandom_range(0, 3));
            for (int i = 0; i < WIDTH; i++) begin
                logic [AW-1:0] rd;
                src1_idx[i*AW +: AW] = AW'($urandom_range(0, 7));
                src2_idx[i*AW +: AW] = AW'($urandom_range(0, 7));
                dest_idx[i*AW +: AW] = AW'($urandom_range(0, 7));
                cdb_tag_in[i*TW +: TW] = $urandom_range(0, 1) ? mtag[$urandom_range(1, 7)] : TW'($urandom);
                rd = AW'($urandom_range(0, 7));
                retire_dest_idx[i*AW +: AW] = rd;
                retire_tag[i*TW +: TW] = $urandom_range(0, 2) != 0 ? mtag[rd] : TW'($urandom);
            end
            flush = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
